// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset / clock-enable generator.
//   - Sequencer state encoding (HOLD -> RELEASE -> RUN).
//   - cnt_width(): width of the hold/gap counter, sized so that it can hold
//     max(hold_cyc, gap_cyc) without wrapping.
package rst_seq_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  typedef enum logic [1:0] {
    StHold    = ST_HOLD,
    StRelease = ST_RELEASE,
    StRun     = ST_RUN
  } seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned gap_cyc);
    int unsigned max_cyc;
    max_cyc = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Per-channel clock-enable divider.
//   Clk    : clock
//   Reset  : synchronous active-high reset (counter and strobe cleared)
//   Run    : counting enabled
//   Ratio  : divide ratio, sampled live; 0 is treated as 1
//   Clk_en : registered one-cycle strobe, once every max(Ratio,1) edges
module clk_en_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [DIV_W-1:0] Ratio,
  output logic             Clk_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last_cnt;
  logic             en_q, en_d;

  always_comb begin
    last_cnt = (Ratio == '0) ? '0 : Ratio - DIV_W'(1);
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    if (Run) begin
      // >= rather than == so a ratio lowered below the current count wraps at once.
      if (cnt_q >= last_cnt) begin
        cnt_d = '0;
        en_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign Clk_en = en_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset / clock-enable generator.
//   Clk       : single clock
//   Reset     : synchronous active-high reset (priority over Soft_rst)
//   Soft_rst  : synchronous active-high restart, level-sensitive
//   Div_ratio : channel i divide ratio at [i*DIV_W +: DIV_W]
//   ResetB    : per-channel active-low resets, released in channel order
//   Clk_en    : per-channel divided enable strobes
//   Seq_done  : high once every channel has been released
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned HOLD_CYC = 20,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Soft_rst,
  input  logic [NUM_CH*DIV_W-1:0] Div_ratio,
  output logic [NUM_CH-1:0]       ResetB,
  output logic [NUM_CH-1:0]       Clk_en,
  output logic                    Seq_done
);

  localparam int unsigned CntW = cnt_width(HOLD_CYC, GAP_CYC);
  // Index must be able to hold NUM_CH (one past the last channel).
  localparam int unsigned IdxW = $clog2(NUM_CH + 1);

  // Compare against count-1 so the release happens on the edge the count reaches the limit.
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_CH - 1);

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] rstb_q, rstb_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstb_d  = rstb_q;
    done_d  = done_q;
    unique case (state_q)
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d     = '0;
          rstb_d[0] = 1'b1;
          idx_d     = IdxW'(1);
          if (NUM_CH == 1) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IdxW'(i)) rstb_d[i] = 1'b1;
          end
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = StRun;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || Soft_rst) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstb_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstb_q  <= rstb_d;
      done_q  <= done_d;
    end
  end

  // Divider resets use the registered ResetB, so a channel starts counting the edge after release.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    logic div_rst;
    assign div_rst = Reset | Soft_rst | ~rstb_q[g];

    clk_en_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .Clk    (Clk),
      .Reset  (div_rst),
      .Run    (rstb_q[g]),
      .Ratio  (Div_ratio[g*DIV_W +: DIV_W]),
      .Clk_en (Clk_en[g])
    );
  end

  assign ResetB   = rstb_q;
  assign Seq_done = done_q;

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Synthesizable, parametrised reset/clock-enable generator; successor to the fixed testbench reset/clock source.
- From one clock, produces NUM_CH staged active-low channel resets, released in order, and one divided clock-enable strobe per channel with a run-time ratio.
- Sits at the top of the MAC/user/register domains.
- Adds a software-reset restart and a sequence-done flag.

Parameters:
- NUM_CH, 3, number of channels (≥1)
- DIV_W, 8, width of each channel's divide ratio
- HOLD_CYC, 20, cycles all channels stay in reset after Reset/Soft_rst removal (≥1)
- GAP_CYC, 4, cycles between consecutive channel releases (≥1)

Ports:
- Clk  in  1  single clock for all logic
- Reset  in  1  synchronous reset, active-high
- Soft_rst  in  1  synchronous restart request, active-high, level-sensitive
- Div_ratio  in  NUM_CH*DIV_W  channel i ratio at bits [i*DIV_W +: DIV_W]
- ResetB  out  NUM_CH  per-channel reset, active-low, registered
- Clk_en  out  NUM_CH  per-channel one-cycle enable strobe, registered
- Seq_done  out  1  high once all channels are released

Behaviour:
- Clk and Reset are the only clock and reset. Reset is synchronous and active-high.
- Reset is sampled on rising Clk. Reset has priority over Soft_rst.
- While Reset is high:
  - ResetB = 0, Clk_en = 0, Seq_done = 0
  - state = HOLD, hold/gap counter = 0, channel index = 0, all divider counters = 0
- Edge numbering: edge 1 is the first rising edge with Reset low (and Soft_rst low).
- FSM states: HOLD, RELEASE, RUN.
- HOLD:
  - Counter increments each edge.
  - On the edge where the counter reaches HOLD_CYC, ResetB[0] <= 1, counter clears, index <= 1, and the state moves to RELEASE (or RUN if NUM_CH = 1).
  - So ResetB[0] rises at edge HOLD_CYC.
- RELEASE:
  - Counter increments each edge.
  - When it reaches GAP_CYC, ResetB[index] <= 1, counter clears, index increments.
  - ResetB[i] rises at edge HOLD_CYC + i*GAP_CYC.
  - On the release of channel NUM_CH-1, Seq_done <= 1 on the same edge and the state moves to RUN.
- RUN: ResetB all 1, Seq_done = 1; only dividers are active.
- Released channels stay released; ResetB bits never fall except via Reset/Soft_rst.
- Soft_rst high in any state: the next edge forces ResetB = 0, Clk_en = 0, Seq_done = 0, state HOLD, counter 0, index 0, dividers 0.
  - Held high, it keeps the block there. The sequence restarts from its falling edge exactly as after Reset.
- Divider, per channel i:
  - Counter cnt_i (DIV_W bits) held at 0 while ResetB[i] = 0.
  - Effective ratio r = max(Div_ratio_i, 1).
  - Each edge with ResetB[i] = 1:
    - if cnt_i ≥ r-1: cnt_i <= 0 and Clk_en[i] <= 1
    - else: cnt_i <= cnt_i + 1 and Clk_en[i] <= 0
  - First strobe is r edges after ResetB[i] rises; strobes then repeat every r edges.
  - Ratios 0 and 1 give a continuous enable starting 1 edge after release.
- Div_ratio is sampled live. Lowering the ratio below the current count wraps on the next edge (one strobe, no counter overflow). Raising it extends the current period.
- Counters are wide enough for max(HOLD_CYC, GAP_CYC); no wrap-around in HOLD/RELEASE.
- No combinational path from inputs to outputs; all outputs come directly from flops.

Decomposition:
- Shared package rst_seq_pkg:
  - state encoding constants ST_HOLD = 2'd0, ST_RELEASE = 2'd1, ST_RUN = 2'd2
  - helper function for counter width: clog2 of max(HOLD_CYC, GAP_CYC) + 1
- One sub-module, clk_en_div (parameter DIV_W; ports Clk, Reset, Run, Ratio, Clk_en), instantiated NUM_CH times in a generate loop. Its Reset is driven by Reset | Soft_rst | ~ResetB[i].
- Sequencer FSM stays in the top module.

Test Plan:
- Power-up, defaults, Div_ratio = {5,2,1}: hold Reset 3 edges then release → ResetB[0] rises at edge 20, ResetB[1] at 24, ResetB[2] at 28; Seq_done rises at edge 28.
- Divider check, same run: Clk_en[0] high every edge from 21; Clk_en[1] first at 26, then every 2; Clk_en[2] first at 33, then every 5; all Clk_en 0 before release.
- Soft_rst pulse of 1 edge at edge 22 → at edge 23 all ResetB/Clk_en/Seq_done = 0; ResetB[0] rises 20 edges after Soft_rst falls.
- Reset asserted mid-RELEASE (edge 25) together with Soft_rst → all outputs 0 next edge; after release the sequence timing is identical to the first scenario.
- Runtime ratio change: channel 2 running at ratio 5 with cnt = 3, ratio set to 2 → strobe on the next edge, then every 2 edges. Ratio 0 behaves as ratio 1.
- NUM_CH = 1, HOLD_CYC = 1, GAP_CYC = 1 → ResetB[0] and Seq_done rise at edge 1, Clk_en[0] at edge 2 with ratio 1; Soft_rst held high 10 edges keeps all outputs 0 throughout.
